// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 19-bit CPU core: program counter, return stack,
// and per-state strobes for IR, register file, data memory and the three accelerators.
module cpu_ctrl_fsm #(
    parameter int PC_W        = 11,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      opcode,
    input  logic [PC_W-1:0] jump_addr,
    input  logic [PC_W-1:0] call_addr,
    input  logic [7:0]      branch_addr,
    input  logic            branch_eq,
    input  logic            acc_done,
    output logic [PC_W-1:0] pc,
    output logic            ir_load,
    output logic            reg_we,
    output logic            mem_re,
    output logic            mem_we,
    output logic            acc_start,
    output logic [1:0]      acc_sel,
    output logic            retire,
    output logic            stack_err
);

    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_JUMP   = 4'h3;
    localparam logic [3:0] OP_BRANCH = 4'h4;
    localparam logic [3:0] OP_LOAD   = 4'h5;
    localparam logic [3:0] OP_STORE  = 4'h6;
    localparam logic [3:0] OP_CALL   = 4'h7;
    localparam logic [3:0] OP_RET    = 4'h8;
    localparam logic [3:0] OP_ENC    = 4'h9;
    localparam logic [3:0] OP_DEC    = 4'hA;
    localparam logic [3:0] OP_FFT    = 4'hB;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ACC_WAIT
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt, pc_inc, br_tgt;
    logic [SP_W-1:0] sp, sp_nxt;
    logic [SP_W-2:0] push_idx, pop_idx;
    logic            stack_err_nxt;
    logic [1:0]      acc_sel_q, acc_sel_nxt;
    logic            push;
    logic            is_acc, is_short;
    logic [PC_W-1:0] stack_mem [STACK_DEPTH];

    assign pc_inc   = pc + 1'b1;
    assign br_tgt   = {{(PC_W-8){1'b0}}, branch_addr};
    assign push_idx = sp[SP_W-2:0];
    assign pop_idx  = sp[SP_W-2:0] - 1'b1;
    assign is_acc   = opcode inside {OP_ENC, OP_DEC, OP_FFT};
    // Opcodes that finish in EXEC itself.
    assign is_short = opcode inside {OP_NOP, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= '0;
            sp        <= '0;
            stack_err <= 1'b0;
            acc_sel_q <= 2'b00;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            sp        <= sp_nxt;
            stack_err <= stack_err_nxt;
            acc_sel_q <= acc_sel_nxt;
        end
    end

    // NOTE: the return stack is plain storage with no reset; sp alone defines which
    // entries are meaningful, so a reset port would only cost flops.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        sp_nxt        = sp;
        stack_err_nxt = stack_err;
        acc_sel_nxt   = acc_sel_q;
        push          = 1'b0;
        unique case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                state_nxt = S_FETCH;
                case (opcode)
                    OP_NOP:    pc_nxt = pc_inc;
                    OP_JUMP:   pc_nxt = jump_addr;
                    OP_BRANCH: pc_nxt = branch_eq ? br_tgt : pc_inc;
                    OP_LOAD, OP_STORE: state_nxt = S_MEM;
                    OP_CALL: begin
                        if (sp < SP_FULL) begin
                            push   = 1'b1;
                            sp_nxt = sp + 1'b1;
                            pc_nxt = call_addr;
                        end else begin
                            stack_err_nxt = 1'b1;
                            pc_nxt        = pc_inc;
                        end
                    end
                    OP_RET: begin
                        if (sp != '0) begin
                            pc_nxt = stack_mem[pop_idx];
                            sp_nxt = sp - 1'b1;
                        end else begin
                            stack_err_nxt = 1'b1;
                            pc_nxt        = pc_inc;
                        end
                    end
                    OP_ENC, OP_DEC, OP_FFT: begin
                        acc_sel_nxt = 2'(opcode - OP_ENC);
                        state_nxt   = S_ACC_WAIT;
                    end
                    default: state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (opcode == OP_LOAD) begin
                    state_nxt = S_WB;
                end else begin
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end
            end
            S_WB: begin
                pc_nxt    = pc_inc;
                state_nxt = S_FETCH;
            end
            S_ACC_WAIT: begin
                if (acc_done) begin
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // acc_sel shows the new selection alongside acc_start, then the held copy.
    always_comb begin
        ir_load   = 1'b0;
        reg_we    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        acc_start = 1'b0;
        retire    = 1'b0;
        acc_sel   = 2'b00;
        if (!rst) begin
            acc_sel = acc_sel_q;
            unique case (state)
                S_DECODE: ir_load = 1'b1;
                S_EXEC: begin
                    retire = is_short;
                    if (is_acc) begin
                        acc_start = 1'b1;
                        acc_sel   = 2'(opcode - OP_ENC);
                    end
                end
                S_MEM: begin
                    mem_re = (opcode == OP_LOAD);
                    mem_we = (opcode == OP_STORE);
                    retire = (opcode == OP_STORE);
                end
                S_WB: begin
                    reg_we = 1'b1;
                    retire = 1'b1;
                end
                S_ACC_WAIT: retire = acc_done;
                default: ;
            endcase
        end
    end

endmodule
